// File: rtl/ad9866_cmd_queue.sv
// ---------------------------------------------------------------------------
// ad9866_cmd_queue
//
// Buffered command master for the AD9866 SPI control slave. Register-write
// commands from the protocol decoder are queued in a small FIFO. Each one is
// then offered to the slave over a request/acknowledge handshake. A command
// the slave refuses (its shifter is busy) is re-issued after a fixed idle
// gap. After MAX_RETRY refusals the command is discarded and a saturating
// drop counter is incremented.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   in_valid   decoder presents a command
//   in_addr    command address (6 bits)
//   in_data    command data (32 bits)
//   in_ready   FIFO can accept a command
//   cmd_addr   address presented to the slave
//   cmd_data   data presented to the slave
//   cmd_rqst   one-cycle request strobe to the slave
//   cmd_ack    slave response, valid the cycle after cmd_rqst (1 = accepted)
//   level      entries held, including the command in flight
//   busy       queue non-empty or state machine not idle
//   drop_count saturating count of dropped commands
// ---------------------------------------------------------------------------
module ad9866_cmd_queue #(
  parameter int DEPTH     = 8,
  parameter int RETRY_GAP = 4,
  parameter int MAX_RETRY = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic [5:0]               cmd_addr,
  output logic [31:0]              cmd_data,
  output logic                     cmd_rqst,
  input  logic                     cmd_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(RETRY_GAP + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [37:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          full;
  logic          push;
  logic          pop;
  logic [37:0]   head;

  // Command sequencer
  state_t        state_reg;
  state_t        state_next;
  logic [7:0]    retry_reg;
  logic [7:0]    retry_next;
  logic [GW-1:0] gap_reg;
  logic [GW-1:0] gap_next;
  logic [7:0]    drop_reg;
  logic [7:0]    drop_next;
  logic          load;
  logic [5:0]    cmd_addr_reg;
  logic [31:0]   cmd_data_reg;

  // A full FIFO refuses a push even when the head pops in the same cycle,
  // so in_ready depends only on the registered count.
  assign full     = (count_reg == LW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_addr, in_data};
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Next-state logic. The head stays in the FIFO (and in level) until the
  // slave accepts it or it is dropped.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    gap_next   = gap_reg;
    drop_next  = drop_reg;
    pop        = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          load       = 1'b1;
          retry_next = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (cmd_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end else if ((9'(retry_reg) + 9'd1) < 9'(MAX_RETRY)) begin
          retry_next = retry_reg + 8'd1;
          gap_next   = GW'(RETRY_GAP);
          state_next = BACKOFF;
        end else begin
          pop        = 1'b1;
          if (drop_reg != 8'hFF) begin
            drop_next = drop_reg + 8'd1;
          end
          state_next = IDLE;
        end
      end
      BACKOFF: begin
        // Leave on the cycle the gap counter reaches zero, giving exactly
        // RETRY_GAP cycles in this state.
        gap_next = gap_reg - GW'(1);
        if (gap_reg <= GW'(1)) begin
          state_next = ISSUE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      retry_reg    <= '0;
      gap_reg      <= '0;
      drop_reg     <= '0;
      cmd_addr_reg <= '0;
      cmd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      retry_reg <= retry_next;
      gap_reg   <= gap_next;
      drop_reg  <= drop_next;
      // Address/data latch once per command and hold across every retry.
      if (load) begin
        cmd_addr_reg <= head[37:32];
        cmd_data_reg <= head[31:0];
      end
    end
  end

  assign cmd_rqst   = (state_reg == ISSUE);
  assign cmd_addr   = cmd_addr_reg;
  assign cmd_data   = cmd_data_reg;
  assign level      = count_reg;
  assign busy       = (count_reg != '0) || (state_reg != IDLE);
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_ad9866_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_ad9866_cmd_queue
//
// Directed self-checking bench for ad9866_cmd_queue (DEPTH 8, RETRY_GAP 4,
// MAX_RETRY 3). A negedge monitor logs every cmd_rqst pulse with its cycle
// number and the presented address/data; each test task compares that log
// and the queue status against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad9866_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_rqst;
  logic        cmd_ack;
  logic [3:0]  level;
  logic        busy;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          c;
    logic [5:0]  a;
    logic [31:0] d;
  } pulse_t;
  pulse_t pulses[$];

  ad9866_cmd_queue #(
    .DEPTH(8),
    .RETRY_GAP(4),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_addr(in_addr),
    .in_data(in_data),
    .in_ready(in_ready),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_rqst(cmd_rqst),
    .cmd_ack(cmd_ack),
    .level(level),
    .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_rqst === 1'b1) pulses.push_back('{cyc, cmd_addr, cmd_data});
  end

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (cmd_rqst !== 1'b0) begin fails++; $display("FAIL reset_rqst: got %b expected 0", cmd_rqst); end
    tests++; if (cmd_addr !== 6'h00) begin fails++; $display("FAIL reset_addr: got %h expected 00", cmd_addr); end
    tests++; if (cmd_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", cmd_data); end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int t0;
    int n = 0;
    pulses.delete();
    cmd_ack = 1'b1;
    in_valid = 1'b1; in_addr = 6'h09; in_data = 32'h5000_0000;
    @(negedge clk);
    t0 = cyc; in_valid = 1'b0;
    tests++; if (level !== 4'd1) begin fails++; $display("FAIL single_level1: got %0d expected 1", level); end
    while (level != 0 && n < 30) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL single_level0: got %0d expected 0", level); end
    tests++; if (pulses.size() != 1) begin fails++; $display("FAIL single_pulses: got %0d expected 1", pulses.size()); end
    if (pulses.size() >= 1) begin
      tests++; if (pulses[0].c != t0 + 1) begin fails++; $display("FAIL single_latency: got cycle %0d expected %0d", pulses[0].c, t0 + 1); end
      tests++; if (pulses[0].a !== 6'h09) begin fails++; $display("FAIL single_addr: got %h expected 09", pulses[0].a); end
      tests++; if (pulses[0].d !== 32'h5000_0000) begin fails++; $display("FAIL single_data: got %h expected 50000000", pulses[0].d); end
    end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL single_drop: got %0d expected 0", drop_count); end
    $display("[TB] single command: %0d pulse(s)", pulses.size());
  endtask

  task automatic test_burst();
    int t0 = 0;
    int n = 0;
    pulses.delete();
    cmd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 6'(6'h30 + i); in_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      if (i == 0) t0 = cyc;
    end
    in_valid = 1'b0;
    // Two pops (edges t0+3, t0+6) overlap the eight pushes.
    tests++; if (level !== 4'd6) begin fails++; $display("FAIL burst_level: got %0d expected 6", level); end
    while ((level != 0 || pulses.size() < 8) && n < 60) begin @(negedge clk); n++; end
    tests++; if (pulses.size() != 8) begin fails++; $display("FAIL burst_pulses: got %0d expected 8", pulses.size()); end
    for (int i = 0; i < 8 && i < pulses.size(); i++) begin
      tests++;
      if (pulses[i].c != t0 + 1 + 3 * i || pulses[i].a !== 6'(6'h30 + i) || pulses[i].d !== 32'hA000_0000 + 32'(i)) begin
        fails++;
        $display("FAIL burst_pulse%0d: got cycle %0d addr %h data %h expected cycle %0d addr %h data %h",
                 i, pulses[i].c, pulses[i].a, pulses[i].d, t0 + 1 + 3 * i, 6'(6'h30 + i), 32'hA000_0000 + 32'(i));
      end
    end
    $display("[TB] burst: %0d pulses", pulses.size());
  endtask

  task automatic test_refusal();
    int t0;
    int n = 0;
    int pops = 0;
    logic [3:0] prev;
    pulses.delete();
    cmd_ack = 1'b0;
    in_valid = 1'b1; in_addr = 6'h15; in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    t0 = cyc; in_valid = 1'b0; prev = level;
    while (!(cmd_ack && level == 0) && n < 80) begin
      @(negedge clk); n++;
      if (pulses.size() >= 2 && cyc >= pulses[1].c + 2) cmd_ack = 1'b1;
      if (level < prev) pops++;
      prev = level;
    end
    tests++; if (pulses.size() != 3) begin fails++; $display("FAIL refusal_pulses: got %0d expected 3", pulses.size()); end
    tests++; if (pops != 1) begin fails++; $display("FAIL refusal_pops: got %0d expected 1", pops); end
    for (int i = 0; i < pulses.size(); i++) begin
      tests++;
      if (pulses[i].c != t0 + 1 + 6 * i || pulses[i].a !== 6'h15 || pulses[i].d !== 32'hDEAD_BEEF) begin
        fails++;
        $display("FAIL refusal_pulse%0d: got cycle %0d addr %h data %h expected cycle %0d addr 15 data deadbeef",
                 i, pulses[i].c, pulses[i].a, pulses[i].d, t0 + 1 + 6 * i);
      end
    end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL refusal_drop: got %0d expected 0", drop_count); end
    $display("[TB] refusal: %0d pulses, %0d pop", pulses.size(), pops);
  endtask

  task automatic test_drop();
    int n = 0;
    pulses.delete();
    cmd_ack = 1'b0;
    in_valid = 1'b1; in_addr = 6'h21; in_data = 32'h1111_1111;
    @(negedge clk);
    in_addr = 6'h22; in_data = 32'h2222_2222;
    @(negedge clk);
    in_valid = 1'b0;
    while (!(cmd_ack && level == 0) && n < 100) begin
      @(negedge clk); n++;
      if (!cmd_ack && pulses.size() >= 3 && cyc >= pulses[2].c + 2) cmd_ack = 1'b1;
    end
    tests++; if (pulses.size() != 4) begin fails++; $display("FAIL drop_pulses: got %0d expected 4", pulses.size()); end
    if (pulses.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (pulses[i].a !== 6'h21 || pulses[i].d !== 32'h1111_1111 || (i > 0 && pulses[i].c != pulses[i-1].c + 6)) begin
          fails++;
          $display("FAIL drop_retry%0d: got cycle %0d addr %h data %h expected addr 21 data 11111111 spacing 6",
                   i, pulses[i].c, pulses[i].a, pulses[i].d);
        end
      end
      tests++;
      if (pulses[3].a !== 6'h22 || pulses[3].d !== 32'h2222_2222 || pulses[3].c != pulses[2].c + 3) begin
        fails++;
        $display("FAIL drop_next: got cycle %0d addr %h data %h expected cycle %0d addr 22 data 22222222",
                 pulses[3].c, pulses[3].a, pulses[3].d, pulses[2].c + 3);
      end
    end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL drop_level: got %0d expected 0", level); end
    $display("[TB] drop: drop_count %0d", drop_count);
  endtask

  task automatic test_full();
    int n = 0;
    bit found = 1'b0;
    pulses.delete();
    cmd_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 6'(6'h38 + i); in_data = 32'h0000_00F0 + 32'(i);
      @(negedge clk);
    end
    tests++; if (level !== 4'd8) begin fails++; $display("FAIL full_level: got %0d expected 8", level); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", in_ready); end
    // Keep offering a ninth command; the next acknowledge frees one slot.
    in_addr = 6'h3F; in_data = 32'h0000_00F9; cmd_ack = 1'b1;
    while (!found && n < 30) begin
      @(negedge clk); n++;
      if (level != 4'd8) found = 1'b1;
    end
    tests++; if (level !== 4'd7 || in_ready !== 1'b1) begin fails++; $display("FAIL full_pop: got level %0d ready %b expected level 7 ready 1", level, in_ready); end
    @(negedge clk);
    tests++; if (level !== 4'd8) begin fails++; $display("FAIL full_refill: got %0d expected 8", level); end
    in_valid = 1'b0;
    n = 0;
    while (level != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    tests++; if (pulses.size() != 10) begin fails++; $display("FAIL full_pulses: got %0d expected 10", pulses.size()); end
    if (pulses.size() == 10) begin
      tests++; if (pulses[9].a !== 6'h3F) begin fails++; $display("FAIL full_last: got %h expected 3f", pulses[9].a); end
    end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL full_drop: got %0d expected 1", drop_count); end
    $display("[TB] full with simultaneous pop: %0d pulses", pulses.size());
  endtask

  task automatic test_saturation();
    int pushed = 0;
    int n = 0;
    bit went_down = 1'b0;
    logic [7:0] prev = drop_count;
    cmd_ack = 1'b0;
    while (!(pushed == 260 && level == 0) && n < 8000) begin
      in_valid = (pushed < 260);
      in_addr = 6'(pushed); in_data = 32'(pushed);
      if (in_valid && in_ready) pushed++;
      @(negedge clk); n++;
      if (drop_count < prev) went_down = 1'b1;
      prev = drop_count;
    end
    in_valid = 1'b0;
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL sat_drain: got level %0d expected 0", level); end
    tests++; if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_count: got %0d expected 255", drop_count); end
    tests++; if (went_down) begin fails++; $display("FAIL sat_wrap: got decreasing drop_count expected monotonic"); end
    $display("[TB] saturation: drop_count %0d after %0d pushes", drop_count, pushed);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int t0;
    pulses.delete();
    cmd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 6'(6'h10 + i); in_data = 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (!(pulses.size() >= 1 && cyc >= pulses[0].c + 3) && n < 40) begin @(negedge clk); n++; end
    rst = 1'b0;
    #1;
    tests++; if (cmd_rqst !== 1'b0) begin fails++; $display("FAIL rstmid_rqst: got %b expected 0", cmd_rqst); end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL rstmid_level: got %0d expected 0", level); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL rstmid_drop: got %0d expected 0", drop_count); end
    tests++; if (cmd_addr !== 6'h00) begin fails++; $display("FAIL rstmid_addr: got %h expected 00", cmd_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses.delete();
    repeat (20) @(negedge clk);
    tests++; if (pulses.size() != 0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_quiet: got %0d pulses busy %b expected 0 pulses busy 0", pulses.size(), busy); end
    cmd_ack = 1'b1;
    in_valid = 1'b1; in_addr = 6'h2A; in_data = 32'h1234_5678;
    @(negedge clk);
    t0 = cyc; in_valid = 1'b0;
    n = 0;
    while (level != 0 && n < 30) begin @(negedge clk); n++; end
    tests++;
    if (pulses.size() != 1 || pulses[0].c != t0 + 1 || pulses[0].a !== 6'h2A) begin
      fails++;
      $display("FAIL rstmid_resume: got %0d pulses expected 1 at cycle %0d addr 2a", pulses.size(), t0 + 1);
    end
    $display("[TB] reset mid-operation: resumed with %0d pulse(s)", pulses.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_refusal();
    test_drop();
    test_full();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
